// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// Channel sequencer feeding a 3-to-8 decoder. Walks the enabled channels of a
// latched mask in ascending order, holds each one for a dwell period, inserts
// blanking cycles between channels, and reports frame completion. All outputs
// come straight from flops so the decoder sees clean per-cycle values.

module decoder_scan_ctrl #(
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               cont_i,
   input  logic [7:0]         mask_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [2:0]         sel_o,
   output logic               sel_en_o,
   output logic               busy_o,
   output logic               frame_done_o
);

   // Blank counter only needs to count down from BLANK_CYC-1.
   localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BLK_W-1:0] BLK_LOAD =
      (BLANK_CYC > 32'sd0) ? BLK_W'(BLANK_CYC - 1) : {BLK_W{1'b0}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DWELL = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   // Lowest set bit of m at or above position 'from'; bit 3 of the result
   // flags that such a bit exists, bits 2:0 give its index.
   function automatic logic [3:0] find_set(input logic [7:0] m, input logic [3:0] from);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (4'(i) >= from)) begin
            r = {1'b1, 3'(i)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Counter preload for a dwell value: the counter runs load..0, so a dwell of
   // N lasts N cycles and a dwell of 0 behaves like 1.
   function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
      if (d == {DWELL_W{1'b0}}) begin
         return {DWELL_W{1'b0}};
      end else begin
         return d - DWELL_W'(1'b1);
      end
   endfunction

   logic [1:0]         state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [BLK_W-1:0]   bcnt_q, bcnt_d;
   logic [2:0]         sel_q, sel_d;
   logic               sel_en_q, sel_en_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;

   logic               adv_s;
   logic [3:0]         next_hi_s;
   logic [3:0]         first_new_s;

   // Candidate channels: next enabled one in the current frame, and the first
   // enabled one of a freshly sampled mask (used at start and frame wrap).
   always_comb begin
      next_hi_s   = find_set(mask_q, {1'b0, idx_q} + 4'd1);
      first_new_s = find_set(mask_i, 4'd0);
   end

   // Next-state logic for the sequencer and its registered outputs.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mask_d       = mask_q;
      dwell_d      = dwell_q;
      cont_d       = cont_q;
      dcnt_d       = dcnt_q;
      bcnt_d       = bcnt_q;
      frame_done_d = 1'b0;
      adv_s        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // stop in the same cycle as start keeps us idle; empty masks are ignored
            if (start_i && !stop_i && (mask_i != 8'd0)) begin
               mask_d  = mask_i;
               dwell_d = dwell_i;
               cont_d  = cont_i;
               idx_d   = first_new_s[2:0];
               dcnt_d  = dwell_load(dwell_i);
               state_d = ST_DWELL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DWELL: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if (dcnt_q != {DWELL_W{1'b0}}) begin
               dcnt_d = dcnt_q - DWELL_W'(1'b1);
            end else if (BLANK_CYC > 32'sd0) begin
               bcnt_d  = BLK_LOAD;
               state_d = ST_BLANK;
            end else begin
               adv_s = 1'b1;
            end
         end
         ST_BLANK: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if (bcnt_q != {BLK_W{1'b0}}) begin
               bcnt_d = bcnt_q - BLK_W'(1'b1);
            end else begin
               adv_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Channel advance: skipped channels cost nothing; at the end of the
      // frame either stop or re-sample mask/dwell for the next frame.
      if (adv_s) begin
         if (next_hi_s[3]) begin
            idx_d   = next_hi_s[2:0];
            dcnt_d  = dwell_load(dwell_q);
            state_d = ST_DWELL;
         end else begin
            frame_done_d = 1'b1;
            if (cont_q) begin
               mask_d  = mask_i;
               dwell_d = dwell_i;
               if (first_new_s[3]) begin
                  idx_d   = first_new_s[2:0];
                  dcnt_d  = dwell_load(dwell_i);
                  state_d = ST_DWELL;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      end else begin
         frame_done_d = 1'b0;
      end

      // sel only moves when idx moves, which happens only on DWELL entry
      sel_d    = idx_d;
      sel_en_d = (state_d == ST_DWELL);
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         mask_q       <= 8'd0;
         dwell_q      <= {DWELL_W{1'b0}};
         cont_q       <= 1'b0;
         dcnt_q       <= {DWELL_W{1'b0}};
         bcnt_q       <= {BLK_W{1'b0}};
         sel_q        <= 3'd0;
         sel_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mask_q       <= mask_d;
         dwell_q      <= dwell_d;
         cont_q       <= cont_d;
         dcnt_q       <= dcnt_d;
         bcnt_q       <= bcnt_d;
         sel_q        <= sel_d;
         sel_en_q     <= sel_en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign sel_o        = sel_q;
   assign sel_en_o     = sel_en_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer that sits directly upstream of the 3-to-8 decoder and drives its `in[2:0]` and `en` inputs. It walks through a programmable mask of up to 8 channels in ascending order, holding each selected channel for a programmable dwell time and inserting blanking cycles between channels. It runs in single-frame or continuous mode and reports frame completion. All outputs are registered, so the decoder's combinational output is glitch-free per cycle.

## Interface

Parameters:
- `DWELL_W`, default 8: width of the `dwell` input.
- `BLANK_CYC`, default 1: number of `sel_en=0` cycles after each channel's dwell; 0 is legal (no blanking).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a frame; sampled only in IDLE.
- `stop` in 1: abort; highest priority after `rst`.
- `cont` in 1: latched at start; 1 = continuous frames, 0 = single frame.
- `mask` in 8: channel enable bits; bit i enables channel i. Latched at start and at each frame boundary.
- `dwell` in DWELL_W: cycles per channel, latched with `mask`. A value of 0 is treated as 1.
- `sel` out 3: channel index to the decoder `in`.
- `sel_en` out 1: to the decoder `en`; high only during dwell cycles.
- `busy` out 1: high in every non-IDLE state.
- `frame_done` out 1: one-cycle pulse at the end of each completed frame.

## Operation

- States: IDLE, DWELL, BLANK.
- Reset: state IDLE, `sel=0`, `sel_en=0`, `busy=0`, `frame_done=0`, internal counters 0.
- IDLE:
  - `start=1` with `mask!=0`: latch `mask`, `dwell` and `cont`. Set `idx` to the lowest set bit of `mask`, load the dwell counter, and go to DWELL.
  - `start` with `mask==0`: ignored; stays in IDLE and no `frame_done`.
- DWELL:
  - `sel=idx`, `sel_en=1`, `busy=1`, for exactly max(dwell,1) cycles.
  - Then go to BLANK if `BLANK_CYC>0`; otherwise perform channel advance.
- BLANK: `sel_en=0`, `sel` holds `idx`. Lasts exactly `BLANK_CYC` cycles, then channel advance.
- Channel advance:
  - If a set bit of the latched mask exists above `idx`, `idx` = the next higher set bit (skipped channels cost no cycles); go to DWELL.
  - If no higher set bit exists, the frame ends:
    - `cont=0`: go to IDLE and pulse `frame_done`.
    - `cont=1`: re-latch `mask` and `dwell`.
      - New `mask!=0`: `idx` = its lowest set bit; go to DWELL and pulse `frame_done`.
      - New `mask==0`: go to IDLE and pulse `frame_done`.
- `start` while `busy`: ignored.
- `stop` in DWELL or BLANK: go to IDLE next cycle; `sel_en=0`, `busy=0`, `sel` holds its value, no `frame_done`.
- `stop` and `start` in the same cycle in IDLE: stay in IDLE.
- `rst` mid-frame: returns all outputs to their reset values at the next edge, regardless of other inputs.
- Changes to `mask` or `dwell` mid-frame have no effect until the next frame boundary.

## Timing

- `start` sampled at edge T gives `sel_en=1` and `busy=1` from cycle T+1; latency is 1 cycle.
- Frame length = Σ over enabled channels of (max(dwell,1) + `BLANK_CYC`).
- `frame_done` is high for exactly 1 cycle, in the cycle immediately after the last BLANK cycle (or after the last DWELL cycle if `BLANK_CYC=0`).
  - `cont=1`: that cycle is also the first DWELL cycle of the next frame (`sel_en=1`).
  - `cont=0`: that cycle is the first IDLE cycle (`busy=0`).
- `sel` changes only on entry to DWELL, so it is never changing while `sel_en=1`.
- `stop` sampled at edge S gives `sel_en=0` and `busy=0` in cycle S+1.

## Test plan

- **Reset:** assert `rst` for 2 cycles mid-frame -> next cycle `sel=0`, `sel_en=0`, `busy=0`, `frame_done=0`.
- **Single frame:** `BLANK_CYC=1`, `mask=8'b0000_0101`, `dwell=2`, `cont=0`, `start` at edge 0 -> cycles 1–2 `sel=0` `sel_en=1`; cycle 3 blank; cycles 4–5 `sel=2` `sel_en=1`; cycle 6 blank; cycle 7 `frame_done=1` `busy=0`.
- **Continuous with mask swap:** `BLANK_CYC=0`, `mask=8'h80`, `dwell=0`, `cont=1`; change `mask` to `8'h03` mid-frame -> cycle 1 `sel=7`; cycle 2 `frame_done=1` `sel=0` `sel_en=1`; cycle 3 `sel=1`; cycle 4 `frame_done=1` `sel=0`.
- **Continuous to empty mask:** same setup as above, then `mask=8'h00` before a frame boundary -> at that boundary `frame_done=1`, `busy=0`, `sel_en=0` thereafter.
- **Stop mid-dwell:** `mask=8'hFF`, `dwell=5`, `stop` in the 3rd cycle of channel 4 -> next cycle `sel_en=0`, `busy=0`, `sel=4`, no `frame_done`; a later `start` restarts at `sel=0`.
- **Ignored starts:** `start` with `mask=0` -> `busy` stays 0. `start` pulsed while `busy` -> frame timing is unchanged from the single-frame reference sequence.
